// File: rtl/risc_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Loader FSM states, command codes and default widths.
package risc_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam int SYNC_DEF   = 2;

    localparam logic [1:0] CMD_DATA  = 2'b00;
    localparam logic [1:0] CMD_BEGIN = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;
    localparam logic [1:0] CMD_HALT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_READY = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous strobe, followed by a
// registered rising-edge detector producing a one-cycle pulse.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/risc_load_ctrl.sv
// Pin-strobed loader: fills instruction memory, verifies an XOR
// checksum, then releases the CPU from reset on command.
module risc_load_ctrl
    import risc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_strobe,
    input  logic [1:0]        ld_cmd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic [2:0]        state,
    output logic              error
);

    // Count must hold both a full-memory load and any byte-sized length.
    localparam int CNT_W = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

    logic              strobe_rise;
    logic              cmd_v;
    logic [1:0]        cmd_q;
    logic [DATA_W-1:0] data_q;

    state_t            cur_state;
    state_t            nxt_state;

    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  len;
    logic [DATA_W-1:0] csum;

    logic              is_data;
    logic              is_begin;
    logic              is_run;
    logic              is_halt;
    logic              wr_en;
    logic              set_err;
    logic              last_byte;
    logic              csum_ok;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ld_strobe),
        .rise  (strobe_rise)
    );

    // Command bus is stable while the strobe is high, so the
    // synchronised edge is a safe moment to sample it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_v  <= 1'b0;
            cmd_q  <= CMD_DATA;
            data_q <= '0;
        end else begin
            cmd_v <= strobe_rise;
            if (strobe_rise) begin
                cmd_q  <= ld_cmd;
                data_q <= ld_data;
            end
        end
    end

    always_comb begin
        is_data  = 1'b0;
        is_begin = 1'b0;
        is_run   = 1'b0;
        is_halt  = 1'b0;
        if (cmd_v) begin
            unique case (1'b1)
                (cmd_q == CMD_DATA):  is_data  = 1'b1;
                (cmd_q == CMD_BEGIN): is_begin = 1'b1;
                (cmd_q == CMD_RUN):   is_run   = 1'b1;
                default:              is_halt  = 1'b1;
            endcase
        end
    end

    assign last_byte = (count == CNT_W'(1));
    assign csum_ok   = (data_q == csum);
    assign len       = (data_q == '0) ? CNT_W'(2 ** ADDR_W)
                                      : CNT_W'(data_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (is_begin) begin
            nxt_state = S_LOAD;
        end else if (cmd_v) begin
            case (cur_state)
                S_LOAD: begin
                    if (is_data) begin
                        nxt_state = last_byte ? S_CHECK : S_LOAD;
                    end else begin
                        nxt_state = S_ERROR;
                    end
                end
                S_CHECK: begin
                    if (is_data && csum_ok) begin
                        nxt_state = S_READY;
                    end else begin
                        nxt_state = S_ERROR;
                    end
                end
                S_READY: begin
                    if (is_run) begin
                        nxt_state = S_RUN;
                    end else if (is_data) begin
                        nxt_state = S_ERROR;
                    end
                end
                S_RUN: begin
                    if (is_halt) begin
                        nxt_state = S_READY;
                    end else if (is_data) begin
                        nxt_state = S_ERROR;
                    end
                end
                S_IDLE:  nxt_state = S_ERROR;
                S_ERROR: nxt_state = S_ERROR;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        set_err = 1'b0;
        if (cur_state == S_LOAD && is_data) begin
            wr_en = 1'b1;
        end
        if (cmd_v && !is_begin && nxt_state == S_ERROR) begin
            set_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr      <= '0;
            count     <= '0;
            csum      <= '0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            mem_we    <= wr_en;
            cpu_rst_n <= (cur_state == S_RUN);
            if (is_begin) begin
                count <= len;
                addr  <= '0;
                csum  <= '0;
                error <= 1'b0;
            end else begin
                if (wr_en) begin
                    mem_addr  <= addr;
                    mem_wdata <= data_q;
                    csum      <= csum ^ data_q;
                    addr      <= addr + ADDR_W'(1);
                    count     <= count - CNT_W'(1);
                end
                if (set_err) begin
                    error <= 1'b1;
                end
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_risc_load_ctrl.sv
// Scoreboard bench for risc_load_ctrl: expected memory writes are queued
// by the stimulus and checked by an independent monitor.
module tb_risc_load_ctrl;

    localparam logic [1:0] C_DATA  = 2'b00;
    localparam logic [1:0] C_BEGIN = 2'b01;
    localparam logic [1:0] C_RUN   = 2'b10;
    localparam logic [1:0] C_HALT  = 2'b11;

    localparam int ST_IDLE  = 0;
    localparam int ST_LOAD  = 1;
    localparam int ST_CHECK = 2;
    localparam int ST_READY = 3;
    localparam int ST_RUN   = 4;
    localparam int ST_ERROR = 5;

    typedef struct {
        int a;
        int d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_strobe = 1'b0;
    logic [1:0] ld_cmd = 2'b00;
    logic [7:0] ld_data = 8'h00;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst_n;
    logic [2:0] state;
    logic       error;

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  we_count = 0;

    always #5 clk = ~clk;

    risc_load_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_strobe (ld_strobe),
        .ld_cmd    (ld_cmd),
        .ld_data   (ld_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .state     (state),
        .error     (error)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            we_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_mem_we", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(mem_addr), e.a);
                chk("wr_data", int'(mem_wdata), e.d);
            end
        end
    end

    task automatic strobe_cmd(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        ld_cmd    = c;
        ld_data   = d;
        ld_strobe = 1'b1;
        repeat (3) @(negedge clk);
        ld_strobe = 1'b0;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        strobe_cmd(c, d);
        repeat (6) @(negedge clk);
    endtask

    task automatic send_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = int'(d);
        exp_q.push_back(e);
        send(C_DATA, d);
    endtask

    task automatic wait_state(input int s, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (int'(state) == s) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk(name, seen, 1);
    endtask

    initial begin
        int base;
        int lat;
        int pulses;

        repeat (4) @(negedge clk);
        chk("rst_state", int'(state), ST_IDLE);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_cpu_rst_n", int'(cpu_rst_n), 0);
        chk("rst_error", int'(error), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic load: 0x11 ^ 0x22 ^ 0x44 = 0x77
        send(C_BEGIN, 8'd3);
        chk("begin_load", int'(state), ST_LOAD);
        send_wr(0, 8'h11);
        send_wr(1, 8'h22);
        send_wr(2, 8'h44);
        chk("len3_check", int'(state), ST_CHECK);
        send(C_DATA, 8'h77);
        chk("csum_ready", int'(state), ST_READY);
        chk("csum_error", int'(error), 0);
        chk("ready_cpu_rst_n", int'(cpu_rst_n), 0);

        // Run / halt with one-cycle cpu_rst_n lag
        strobe_cmd(C_RUN, 8'h00);
        wait_state(ST_RUN, "run_reached");
        chk("run_cpu_rst_n_lag", int'(cpu_rst_n), 0);
        @(negedge clk);
        chk("run_cpu_rst_n", int'(cpu_rst_n), 1);
        repeat (8) @(negedge clk);
        send(C_HALT, 8'h00);
        chk("halt_ready", int'(state), ST_READY);
        chk("halt_cpu_rst_n", int'(cpu_rst_n), 0);

        // Bad checksum: 0x01 ^ 0x02 = 0x03, not 0x00
        send(C_BEGIN, 8'd2);
        send_wr(0, 8'h01);
        send_wr(1, 8'h02);
        send(C_DATA, 8'h00);
        chk("badsum_state", int'(state), ST_ERROR);
        chk("badsum_error", int'(error), 1);
        send(C_BEGIN, 8'd5);
        chk("recover_state", int'(state), ST_LOAD);
        chk("recover_error", int'(error), 0);

        // Full 128-byte load via len=0; bytes i^0x5A XOR to 0x00
        send(C_BEGIN, 8'd0);
        base = we_count;
        for (int i = 0; i < 128; i++) begin
            send_wr(i, 8'(i) ^ 8'h5A);
            if (i == 126) begin
                chk("full_still_load", int'(state), ST_LOAD);
            end
        end
        chk("full_check", int'(state), ST_CHECK);
        chk("full_we_count", we_count - base, 128);
        send(C_DATA, 8'h00);
        chk("full_ready", int'(state), ST_READY);

        // Reset in the middle of a load
        send(C_BEGIN, 8'd4);
        send_wr(0, 8'hA1);
        send_wr(1, 8'hB2);
        base = we_count;
        @(negedge clk);
        ld_cmd    = C_DATA;
        ld_data   = 8'hC3;
        ld_strobe = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ld_strobe = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_state", int'(state), ST_IDLE);
        chk("midrst_no_we", we_count - base, 0);
        chk("midrst_cpu_rst_n", int'(cpu_rst_n), 0);
        chk("midrst_addr", int'(mem_addr), 0);

        // Long strobe: one write, latency SYNC_STAGES+2 = 4
        send(C_BEGIN, 8'd1);
        begin
            wr_t e;
            e.a = 0;
            e.d = 8'h3C;
            exp_q.push_back(e);
        end
        @(negedge clk);
        ld_cmd    = C_DATA;
        ld_data   = 8'h3C;
        ld_strobe = 1'b1;
        lat    = -1;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) ld_strobe = 1'b0;
            if (mem_we) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        chk("long_latency", lat, 4);
        chk("long_pulses", pulses, 1);
        @(negedge clk);
        chk("long_check", int'(state), ST_CHECK);

        // Protocol errors: RUN in CHECK, then ERROR is sticky
        send(C_RUN, 8'h00);
        chk("proto_err_state", int'(state), ST_ERROR);
        chk("proto_err_flag", int'(error), 1);
        send(C_HALT, 8'h00);
        chk("error_sticky", int'(state), ST_ERROR);

        repeat (4) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("total_we", we_count, 136);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
